// File: rtl/instr_loader_tx_pkg.sv
// Shared constants and FSM encoding for the byte-serial instruction-load transmitter.
// The memory-side checker imports this package as well.
package instr_loader_tx_pkg;

  localparam logic [7:0] MARK_BYTE    = 8'hFE;
  localparam logic [7:0] TERM_BYTE    = 8'hFF;
  localparam logic [5:0] SCRATCH_ADDR = 6'd63;
  localparam logic [5:0] MAX_LEN      = 6'd62;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MARK  = 3'd1,
    S_FETCH = 3'd2,
    S_BYTE  = 3'd3,
    S_TERM  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // A word holding 8'hFF anywhere cannot be streamed: the receiver would take it as a terminator.
  function automatic logic has_term_byte(input logic [31:0] w);
    return (w[31:24] == TERM_BYTE) || (w[23:16] == TERM_BYTE) ||
           (w[15:8]  == TERM_BYTE) || (w[7:0]   == TERM_BYTE);
  endfunction

endpackage

// File: rtl/instr_byte_serializer.sv
// Splits one 32-bit word into 4 bytes, MSB first, each held for BYTE_HOLD+1 cycles.
// The load cycle is already byte 0's first hold cycle, so the word bypasses straight to byte_o.
module instr_byte_serializer #(
  parameter int BYTE_HOLD = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] word_i,
  output logic [7:0]  byte_o,
  output logic [1:0]  counter_o,
  output logic        last_o,
  output logic        pre_last_o
);

  localparam int HW = (BYTE_HOLD > 0) ? $clog2(BYTE_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(BYTE_HOLD);

  logic [31:0]   word_q, word_eff;
  logic [1:0]    cnt_q, cnt_d, cnt_eff;
  logic [HW-1:0] hold_q, hold_d, hold_eff;
  logic          active_q, active_d, active_eff;

  always_comb begin
    active_eff = load_i | active_q;
    cnt_eff    = load_i ? 2'd0 : cnt_q;
    hold_eff   = load_i ? '0 : hold_q;
    word_eff   = load_i ? word_i : word_q;
    cnt_d      = cnt_eff;
    hold_d     = hold_eff;
    active_d   = active_eff;
    if (active_eff) begin
      if (hold_eff == HOLD_MAX) begin
        hold_d = '0;
        cnt_d  = cnt_eff + 2'd1;
        if (cnt_eff == 2'd3) active_d = 1'b0;
      end else begin
        hold_d = hold_eff + HW'(1);
      end
    end
    last_o     = active_eff && (cnt_eff == 2'd3) && (hold_eff == HOLD_MAX);
    pre_last_o = active_d && (cnt_d == 2'd3) && (hold_d == HOLD_MAX);
    counter_o  = cnt_eff;
    case (cnt_eff)
      2'd0:    byte_o = word_eff[31:24];
      2'd1:    byte_o = word_eff[23:16];
      2'd2:    byte_o = word_eff[15:8];
      default: byte_o = word_eff[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q   <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
      active_q <= 1'b0;
    end else begin
      if (load_i) word_q <= word_i;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/instr_loader_tx.sv
// Streams a program into Instruction_Memory: FE, 4 bytes per word MSB first, then FF.
// Source handshake: src_rd_en_o/src_addr_o in cycle c, src_data_i valid and captured in c+1.
module instr_loader_tx
  import instr_loader_tx_pkg::*;
#(
  parameter int         BYTE_HOLD = 0,
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [5:0]  len_i,
  output logic        src_rd_en_o,
  output logic [5:0]  src_addr_o,
  input  logic [31:0] src_data_i,
  output logic [7:0]  instr_o,
  output logic [5:0]  instr_wr_address_o,
  output logic [1:0]  counter_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output state_e      state_o
);

  localparam int HW = (BYTE_HOLD > 0) ? $clog2(BYTE_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(BYTE_HOLD);

  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [5:0]    len_q, len_d, idx_q, idx_d, rd_addr_q, rd_addr_d;
  logic          err_q, err_d, rd_en_q, rd_en_d;
  logic          word_bad, more_words, ser_load, ser_last, ser_pre_last;
  logic [7:0]    ser_byte;
  logic [1:0]    ser_cnt;

  assign word_bad   = has_term_byte(src_data_i);
  assign more_words = ({1'b0, idx_q} + 7'd1) < {1'b0, len_q};
  assign ser_load   = (state_q == S_FETCH) && !word_bad;

  instr_byte_serializer #(.BYTE_HOLD(BYTE_HOLD)) u_ser (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (ser_load),
    .word_i     (src_data_i),
    .byte_o     (ser_byte),
    .counter_o  (ser_cnt),
    .last_o     (ser_last),
    .pre_last_o (ser_pre_last)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    len_d   = len_q;
    idx_d   = idx_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_i > MAX_LEN) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            len_d   = len_i;
            idx_d   = '0;
            hold_d  = '0;
            state_d = S_MARK;
          end
        end
      end
      S_MARK: begin
        if (hold_q == HOLD_MAX) begin
          hold_d  = '0;
          state_d = (len_q == 6'd0) ? S_TERM : S_FETCH;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      // Capture cycle: a bad word turns this slot into the first terminator cycle.
      S_FETCH: begin
        if (word_bad) begin
          err_d = 1'b1;
          if (HOLD_MAX == '0) begin
            state_d = S_DONE;
          end else begin
            hold_d  = HW'(1);
            state_d = S_TERM;
          end
        end else begin
          state_d = S_BYTE;
        end
      end
      S_BYTE: begin
        if (ser_last) begin
          hold_d = '0;
          if (more_words) begin
            idx_d   = idx_q + 6'd1;
            state_d = S_FETCH;
          end else begin
            state_d = S_TERM;
          end
        end
      end
      S_TERM: begin
        if (hold_q == HOLD_MAX) begin
          hold_d  = '0;
          state_d = S_DONE;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Reads land in the last hold cycle of the preceding byte so the next word follows gap-free.
    rd_en_d   = ((state_d == S_MARK) && (hold_d == HOLD_MAX) && (len_d != 6'd0)) ||
                (((state_q == S_FETCH) || (state_q == S_BYTE)) && ser_pre_last && more_words);
    rd_addr_d = ((state_q == S_FETCH) || (state_q == S_BYTE)) ? (idx_q + 6'd1) : 6'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      hold_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  always_comb begin
    instr_o            = IDLE_BYTE;
    instr_wr_address_o = '0;
    counter_o          = '0;
    case (state_q)
      S_MARK: begin
        instr_o            = MARK_BYTE;
        instr_wr_address_o = SCRATCH_ADDR;
        counter_o          = 2'd3;
      end
      S_TERM: begin
        instr_o            = TERM_BYTE;
        instr_wr_address_o = SCRATCH_ADDR;
        counter_o          = 2'd3;
      end
      S_FETCH: begin
        instr_o            = word_bad ? TERM_BYTE : ser_byte;
        instr_wr_address_o = word_bad ? SCRATCH_ADDR : idx_q;
        counter_o          = word_bad ? 2'd3 : ser_cnt;
      end
      S_BYTE: begin
        instr_o            = ser_byte;
        instr_wr_address_o = idx_q;
        counter_o          = ser_cnt;
      end
      default: ;
    endcase
  end

  assign src_rd_en_o = rd_en_q;
  assign src_addr_o  = rd_addr_q;
  assign busy_o      = (state_q == S_MARK) || (state_q == S_FETCH) ||
                       (state_q == S_BYTE) || (state_q == S_TERM);
  assign done_o      = (state_q == S_DONE);
  assign err_o       = err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_instr_loader_tx.sv
// Directed bench: two loaders (BYTE_HOLD 0 and 2), each with a word-source model and a
// receiver model that writes bytes into a 64-word memory the way Instruction_Memory does.
module tb_instr_loader_tx;
  import instr_loader_tx_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_s [2];
  logic [5:0]  len_s   [2];
  logic        rd_s    [2];
  logic [5:0]  raddr_s [2];
  logic [31:0] rdata_s [2];
  logic [7:0]  instr_s [2];
  logic [5:0]  waddr_s [2];
  logic [1:0]  cnt_s   [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic        err_s   [2];
  state_e      st_s    [2];

  logic [31:0] src_mem [2][64];
  logic [31:0] rx_mem  [2][64];
  logic        armed   [2];
  logic [31:0] fill_val;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int   done_cyc, rd_cnt;
  logic err_at_done, busy_at_done;
  logic [7:0] instr_at_done;

  always #5 clk = ~clk;

  instr_loader_tx #(.BYTE_HOLD(0), .IDLE_BYTE(8'h00)) dut0 (
    .clk(clk), .reset(reset), .start_i(start_s[0]), .len_i(len_s[0]),
    .src_rd_en_o(rd_s[0]), .src_addr_o(raddr_s[0]), .src_data_i(rdata_s[0]),
    .instr_o(instr_s[0]), .instr_wr_address_o(waddr_s[0]), .counter_o(cnt_s[0]),
    .busy_o(busy_s[0]), .done_o(done_s[0]), .err_o(err_s[0]), .state_o(st_s[0])
  );

  instr_loader_tx #(.BYTE_HOLD(2), .IDLE_BYTE(8'h00)) dut2 (
    .clk(clk), .reset(reset), .start_i(start_s[1]), .len_i(len_s[1]),
    .src_rd_en_o(rd_s[1]), .src_addr_o(raddr_s[1]), .src_data_i(rdata_s[1]),
    .instr_o(instr_s[1]), .instr_wr_address_o(waddr_s[1]), .counter_o(cnt_s[1]),
    .busy_o(busy_s[1]), .done_o(done_s[1]), .err_o(err_s[1]), .state_o(st_s[1])
  );

  // Source: synchronous read, data one cycle after the strobe. Receiver: FE arms, FF writes 0 and disarms.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rd_s[g]) rdata_s[g] <= src_mem[g][raddr_s[g]];
      if (!reset) begin
        armed[g] = 1'b0;
        for (int i = 0; i < 64; i++) rx_mem[g][i] = fill_val;
      end else if (instr_s[g] == 8'hFE || armed[g]) begin
        rx_mem[g][waddr_s[g]][(3 - int'(cnt_s[g])) * 8 +: 8] = (instr_s[g] == 8'hFF) ? 8'h00 : instr_s[g];
        armed[g] = (instr_s[g] != 8'hFF);
      end
    end
  end

  task automatic apply_reset(input logic [31:0] fv);
    fill_val = fv;
    reset = 1'b0;
    for (int g = 0; g < 2; g++) begin
      start_s[g] = 1'b0;
      len_s[g]   = 6'd0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Expected {address, counter, byte} per cycle, straight from the frame format.
  task automatic build_exp(input int g, input int l, input int hold);
    logic [31:0] wd;
    exp_q.delete();
    repeat (hold + 1) exp_q.push_back({6'd63, 2'd3, 8'hFE});
    for (int w = 0; w < l; w++) begin
      wd = src_mem[g][w];
      if (wd[31:24] == 8'hFF || wd[23:16] == 8'hFF || wd[15:8] == 8'hFF || wd[7:0] == 8'hFF) break;
      for (int b = 0; b < 4; b++)
        repeat (hold + 1) exp_q.push_back({6'(w), 2'(b), wd[31 - 8 * b -: 8]});
    end
    repeat (hold + 1) exp_q.push_back({6'd63, 2'd3, 8'hFF});
  endtask

  function automatic int stream_diff();
    int d = (obs_q.size() > exp_q.size()) ? obs_q.size() - exp_q.size() : exp_q.size() - obs_q.size();
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) d++;
    return d;
  endfunction

  // Pulses start, then records the stream cycle by cycle (cycle 0 = first cycle after start).
  task automatic run(input int g, input logic [5:0] l, input bit glitch);
    obs_q.delete();
    rd_cnt   = 0;
    done_cyc = -1;
    @(negedge clk);
    start_s[g] = 1'b1;
    len_s[g]   = l;
    @(negedge clk);
    start_s[g] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (glitch && c == 5) begin start_s[g] = 1'b1; len_s[g] = 6'd1; end
      if (glitch && c == 6) start_s[g] = 1'b0;
      if (busy_s[g]) obs_q.push_back({waddr_s[g], cnt_s[g], instr_s[g]});
      if (rd_s[g]) rd_cnt++;
      if (done_s[g]) begin
        done_cyc      = c;
        err_at_done   = err_s[g];
        busy_at_done  = busy_s[g];
        instr_at_done = instr_s[g];
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    apply_reset(32'h0);
    checks++; if (instr_s[0] !== 8'h00) begin errors++; $display("FAIL reset_instr got %h exp 00", instr_s[0]); end
    checks++; if ({waddr_s[0], cnt_s[0]} !== 8'h00) begin errors++; $display("FAIL reset_addr_cnt got %h exp 00", {waddr_s[0], cnt_s[0]}); end
    checks++; if ({busy_s[0], done_s[0], err_s[0], rd_s[0]} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {busy_s[0], done_s[0], err_s[0], rd_s[0]}); end
    checks++; if (st_s[0] !== S_IDLE || st_s[1] !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d/%0d exp 0/0", st_s[0], st_s[1]); end
    checks++; if (instr_s[1] !== 8'h00) begin errors++; $display("FAIL reset_instr_h2 got %h exp 00", instr_s[1]); end
  endtask

  task automatic test_basic();
    int d;
    apply_reset(32'h0);
    src_mem[0][0] = 32'h00500093; src_mem[0][1] = 32'h00100113; src_mem[0][2] = 32'h002081B3;
    build_exp(0, 3, 0);
    run(0, 6'd3, 1'b0);
    d = stream_diff();
    checks++; if (d !== 0) begin errors++; $display("FAIL basic_stream diffs %0d got len %0d exp len %0d", d, obs_q.size(), exp_q.size()); end
    checks++; if (done_cyc !== 14) begin errors++; $display("FAIL basic_done_cycle got %0d exp 14", done_cyc); end
    checks++; if (rd_cnt !== 3) begin errors++; $display("FAIL basic_reads got %0d exp 3", rd_cnt); end
    checks++; if (busy_at_done !== 1'b0 || err_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_err got %b%b exp 00", busy_at_done, err_at_done); end
    @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      checks++; if (rx_mem[0][w] !== src_mem[0][w]) begin errors++; $display("FAIL basic_mem%0d got %h exp %h", w, rx_mem[0][w], src_mem[0][w]); end
    end
    checks++; if (rx_mem[0][63][7:0] !== 8'h00) begin errors++; $display("FAIL basic_scratch got %h exp 00", rx_mem[0][63][7:0]); end
  endtask

  task automatic test_len0();
    int nd = 0;
    apply_reset(32'hA5A5A5A5);
    build_exp(0, 0, 0);
    run(0, 6'd0, 1'b0);
    checks++; if (stream_diff() !== 0) begin errors++; $display("FAIL len0_stream got len %0d exp len 2", obs_q.size()); end
    checks++; if (done_cyc !== 2) begin errors++; $display("FAIL len0_done_cycle got %0d exp 2", done_cyc); end
    checks++; if (rd_cnt !== 0) begin errors++; $display("FAIL len0_reads got %0d exp 0", rd_cnt); end
    @(negedge clk);
    for (int i = 0; i < 63; i++) if (rx_mem[0][i] !== 32'hA5A5A5A5) nd++;
    checks++; if (nd !== 0) begin errors++; $display("FAIL len0_mem_touched got %0d words changed exp 0", nd); end
    checks++; if (rx_mem[0][63] !== 32'hA5A5A500) begin errors++; $display("FAIL len0_scratch got %h exp a5a5a500", rx_mem[0][63]); end
  endtask

  task automatic test_ff_word();
    apply_reset(32'h0);
    src_mem[0][0] = 32'h00500093; src_mem[0][1] = 32'h12FF3456;
    build_exp(0, 2, 0);
    run(0, 6'd2, 1'b0);
    checks++; if (stream_diff() !== 0) begin errors++; $display("FAIL ffword_stream got len %0d exp len %0d", obs_q.size(), exp_q.size()); end
    checks++; if (done_cyc !== 6) begin errors++; $display("FAIL ffword_done_cycle got %0d exp 6", done_cyc); end
    checks++; if (err_at_done !== 1'b1) begin errors++; $display("FAIL ffword_err got %b exp 1", err_at_done); end
    @(negedge clk);
    checks++; if (err_s[0] !== 1'b1) begin errors++; $display("FAIL ffword_err_sticky got %b exp 1", err_s[0]); end
    checks++; if (rx_mem[0][0] !== 32'h00500093) begin errors++; $display("FAIL ffword_mem0 got %h exp 00500093", rx_mem[0][0]); end
    checks++; if (rx_mem[0][1] !== 32'h0) begin errors++; $display("FAIL ffword_mem1 got %h exp 0", rx_mem[0][1]); end
  endtask

  task automatic test_hold();
    apply_reset(32'h0);
    src_mem[1][0] = 32'hDEADBEEF;
    build_exp(1, 1, 2);
    run(1, 6'd1, 1'b0);
    checks++; if (stream_diff() !== 0) begin errors++; $display("FAIL hold_stream got len %0d exp len 18", obs_q.size()); end
    checks++; if (done_cyc !== 18) begin errors++; $display("FAIL hold_done_cycle got %0d exp 18", done_cyc); end
    checks++; if (rd_cnt !== 1) begin errors++; $display("FAIL hold_reads got %0d exp 1", rd_cnt); end
    @(negedge clk);
    checks++; if (rx_mem[1][0] !== 32'hDEADBEEF) begin errors++; $display("FAIL hold_mem0 got %h exp deadbeef", rx_mem[1][0]); end
  endtask

  task automatic test_bad_len();
    apply_reset(32'h0);
    run(0, 6'd63, 1'b0);
    checks++; if (done_cyc !== 0) begin errors++; $display("FAIL badlen_done_cycle got %0d exp 0", done_cyc); end
    checks++; if (err_at_done !== 1'b1 || busy_at_done !== 1'b0) begin errors++; $display("FAIL badlen_err_busy got %b%b exp 10", err_at_done, busy_at_done); end
    checks++; if (instr_at_done !== 8'h00 || obs_q.size() !== 0) begin errors++; $display("FAIL badlen_no_stream got %h/%0d exp 00/0", instr_at_done, obs_q.size()); end
    src_mem[0][0] = 32'h00000013;
    build_exp(0, 1, 0);
    run(0, 6'd1, 1'b0);
    checks++; if (err_at_done !== 1'b0) begin errors++; $display("FAIL badlen_err_cleared got %b exp 0", err_at_done); end
    checks++; if (stream_diff() !== 0) begin errors++; $display("FAIL badlen_restart_stream got len %0d exp len 6", obs_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit hit = 1'b0;
    apply_reset(32'h0);
    src_mem[0][0] = 32'h11223344; src_mem[0][1] = 32'hFE00FE01;
    src_mem[0][2] = 32'h0A0B0C0D; src_mem[0][3] = 32'h76543210;
    @(negedge clk);
    start_s[0] = 1'b1; len_s[0] = 6'd4;
    @(negedge clk);
    start_s[0] = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      if (busy_s[0] && waddr_s[0] == 6'd1) hit = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!hit) begin errors++; $display("FAIL midreset_reach_word1 got timeout exp word 1"); end
    reset = 1'b0;
    #1;
    checks++; if (instr_s[0] !== 8'h00 || busy_s[0] !== 1'b0) begin errors++; $display("FAIL midreset_async got %h/%b exp 00/0", instr_s[0], busy_s[0]); end
    @(negedge clk);
    reset = 1'b1;
    build_exp(0, 4, 0);
    run(0, 6'd4, 1'b1);
    checks++; if (stream_diff() !== 0) begin errors++; $display("FAIL restart_stream got len %0d exp len %0d", obs_q.size(), exp_q.size()); end
    checks++; if (done_cyc !== 18 || rd_cnt !== 4) begin errors++; $display("FAIL restart_timing got done %0d reads %0d exp 18/4", done_cyc, rd_cnt); end
    repeat (3) @(negedge clk);
    checks++; if (busy_s[0] !== 1'b0) begin errors++; $display("FAIL restart_no_rerun got busy %b exp 0", busy_s[0]); end
    for (int w = 0; w < 4; w++) begin
      checks++; if (rx_mem[0][w] !== src_mem[0][w]) begin errors++; $display("FAIL restart_mem%0d got %h exp %h", w, rx_mem[0][w], src_mem[0][w]); end
    end
  endtask

  initial begin
    for (int g = 0; g < 2; g++)
      for (int i = 0; i < 64; i++) src_mem[g][i] = 32'h0;
    test_reset();
    test_basic();
    test_len0();
    test_ff_word();
    test_hold();
    test_bad_len();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
